multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle sequencer for the MIPS datapath: a Moore FSM that steps each instruction
//  through fetch, decode, execute, memory and write-back. It drives one shared ALU, one
//  shared memory port and the register file, and replaces single-cycle opcode decode.
//  Memory accesses stall on a ready handshake. The 3-bit ALU-op encoding is the existing one:
//  000 lui, 001 or, 010 and, 011 sub, 100 add, 111 R-type/funct.
// PARAMETERS
//  USE_MEM_READY  1  1: honour mem_ready_i; 0: mem_ready_i is ignored and treated as 1
// PORTS
//  clk               in   1  rising-edge clock, the only clock
//  reset             in   1  asynchronous, active-high; returns FSM to FETCH
//  opcode_i          in   6  IR[31:26]; stable from the cycle after FETCH completes
//  mem_ready_i       in   1  memory completes the current read/write this cycle
//  pc_write_o        out  1  unconditional PC load
//  pc_write_eq_o     out  1  PC load if ALU zero (beq)
//  pc_write_ne_o     out  1  PC load if ALU not zero (bne)
//  pc_source_o       out  2  00 ALU result, 01 ALUOut register (branch target), 10 jump target
//  ir_write_o        out  1  load instruction register
//  i_or_d_o          out  1  memory address: 0 PC, 1 ALUOut
//  mem_read_o        out  1  memory read request
//  mem_write_o       out  1  memory write request
//  mem_to_reg_o      out  1  write-back data: 1 MDR, 0 ALUOut
//  reg_dst_o         out  1  destination: 1 rd, 0 rt
//  reg_write_o       out  1  register-file write enable
//  alu_src_a_o       out  1  0 PC, 1 register A
//  alu_src_b_o       out  2  00 register B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op_o          out  3  ALU operation, encoding as in PURPOSE
//  state_o           out  4  current state code, for debug/verification
//  instr_done_o      out  1  high in the final cycle of every instruction
//  illegal_op_o      out  1  high for one cycle on an unsupported opcode
// BEHAVIOUR
//  - State register only; every output decodes from the state and the opcode latched in DECODE
//    (op_r). Exception: FETCH gating by mem_ready_i, defined below.
//  - Codes: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXEC_R,
//    7 R_WB, 8 EXEC_I, 9 I_WB, 10 BRANCH, 11 JUMP, 12 ILLEGAL. Codes 13-15 go to FETCH next cycle.
//  - Reset: state=FETCH, op_r=0. While reset is high, pc_write_o=ir_write_o=0; all other
//    outputs show FETCH values. Reset mid-instruction aborts it with no further writes.
//  - FETCH: mem_read=1, i_or_d=0, a=0, b=01, alu_op=100, pc_source=00.
//    ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
//  - DECODE: a=0, b=11, alu_op=100 (branch target into ALUOut); latch op_r=opcode_i. Next state:
//    0x00->EXEC_R; 0x08/0x0c/0x0d/0x0f->EXEC_I; 0x23/0x2b->MEM_ADDR; 0x04/0x05->BRANCH;
//    0x02->JUMP; others->ILLEGAL.
//  - EXEC_R: a=1, b=00, alu_op=111 -> R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, done.
//  - EXEC_I: a=1, b=10, alu_op from op_r (08:100, 0c:010, 0d:001, 0f:000) -> I_WB.
//    I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, done.
//  - MEM_ADDR: a=1, b=10, alu_op=100 -> MEM_READ if op_r=0x23, else MEM_WRITE.
//  - MEM_READ: i_or_d=1, mem_read=1; waits for mem_ready, then goes to MEM_WB.
//    MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, done.
//  - MEM_WRITE: i_or_d=1, mem_write=1; waits for mem_ready, then goes to FETCH; done=mem_ready.
//  - BRANCH: a=1, b=00, alu_op=011, pc_source=01; pc_write_eq=(op_r=0x04),
//    pc_write_ne=(op_r=0x05); done -> FETCH.
//  - JUMP: pc_write=1, pc_source=10, done -> FETCH. ILLEGAL: illegal_op=1, done -> FETCH;
//    PC was already advanced, so the instruction is skipped.
//  - All outputs not listed for a state are 0. mem_read and mem_write are never both high.
//  - Latency from FETCH completion, with zero wait states: R/I-ALU 4, lw 5, sw 4, beq/bne/j 3,
//    illegal 3 cycles. Each asserted mem_ready_i=0 cycle adds exactly one cycle.
// TESTING
//  - Reset held 3 cycles, then released with mem_ready=1: state_o=0 during reset, pc_write=0;
//    first cycle after release has pc_write=ir_write=1.
//  - opcode 0x00, zero wait: states 0,1,6,7; reg_write=1 and reg_dst=1 only in state 7;
//    done in cycle 4.
//  - lw (0x23) with mem_ready low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4;
//    mem_to_reg=1 in state 4 only.
//  - beq (0x04), then bne (0x05): state 10 shows alu_op=011 and pc_source=01;
//    pc_write_eq=1 for beq only, pc_write_ne=1 for bne only.
//  - opcode 0x3f: states 0,1,12; illegal_op=1 for exactly one cycle; next instruction fetches.
//  - Async reset in MEM_WRITE with mem_ready=0: state_o=0 immediately, without waiting for clk;
//    mem_write drops to 0 the same time.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath/memory.
// master : sequencer side (consumes opcode/mem_ready, drives all control lines)
// slave  : datapath side (drives opcode/mem_ready, consumes all control lines)
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_eq_o;
  logic       pc_write_ne_o;
  logic [1:0] pc_source_o;
  logic       ir_write_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       mem_to_reg_o;
  logic       reg_dst_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       instr_done_o;
  logic       illegal_op_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o, ir_write_o,
           i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o,
           reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, state_o,
           instr_done_o, illegal_op_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o, ir_write_o,
           i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o,
           reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, state_o,
           instr_done_o, illegal_op_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: Moore FSM stepping each instruction through
// fetch, decode, execute, memory and write-back, sharing one ALU and one
// memory port. Memory accesses stall on mem_ready_i.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high, returns to FETCH
//   bus   - multicycle_control_if.master: opcode/mem_ready in, all control out
// ALU op encoding: 000 lui, 001 or, 010 and, 011 sub, 100 add, 111 funct.
module multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       w_ready;

  assign w_ready = USE_MEM_READY ? bus.mem_ready_i : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= bus.opcode_i;
    end
  end

  always_comb begin
    w_next            = S_FETCH;
    bus.pc_write_o    = 1'b0;
    bus.pc_write_eq_o = 1'b0;
    bus.pc_write_ne_o = 1'b0;
    bus.pc_source_o   = 2'b00;
    bus.ir_write_o    = 1'b0;
    bus.i_or_d_o      = 1'b0;
    bus.mem_read_o    = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_to_reg_o  = 1'b0;
    bus.reg_dst_o     = 1'b0;
    bus.reg_write_o   = 1'b0;
    bus.alu_src_a_o   = 1'b0;
    bus.alu_src_b_o   = 2'b00;
    bus.alu_op_o      = 3'b000;
    bus.instr_done_o  = 1'b0;
    bus.illegal_op_o  = 1'b0;

    case (r_state)
      S_FETCH: begin
        bus.mem_read_o  = 1'b1;
        bus.alu_src_b_o = 2'b01;
        bus.alu_op_o    = 3'b100;
        // Reset is async, so the state already reads FETCH while it is held;
        // the write strobes must be masked directly to avoid PC/IR loads.
        bus.ir_write_o  = w_ready & ~reset;
        bus.pc_write_o  = w_ready & ~reset;
        w_next          = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_b_o = 2'b11;
        bus.alu_op_o    = 3'b100;
        case (bus.opcode_i)
          6'h00:                      w_next = S_EXEC_R;
          6'h08, 6'h0c, 6'h0d, 6'h0f: w_next = S_EXEC_I;
          6'h23, 6'h2b:               w_next = S_MEM_ADDR;
          6'h04, 6'h05:               w_next = S_BRANCH;
          6'h02:                      w_next = S_JUMP;
          default:                    w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b00;
        bus.alu_op_o    = 3'b111;
        w_next          = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_dst_o    = 1'b1;
        bus.reg_write_o  = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        case (r_op)
          6'h0c:   bus.alu_op_o = 3'b010;
          6'h0d:   bus.alu_op_o = 3'b001;
          6'h0f:   bus.alu_op_o = 3'b000;
          default: bus.alu_op_o = 3'b100;
        endcase
        w_next = S_I_WB;
      end
      S_I_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        bus.alu_op_o    = 3'b100;
        w_next          = (r_op == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.i_or_d_o   = 1'b1;
        bus.mem_read_o = 1'b1;
        w_next         = w_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        bus.mem_to_reg_o = 1'b1;
        bus.reg_write_o  = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.i_or_d_o     = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.instr_done_o = w_ready;
        w_next           = w_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        bus.alu_src_a_o   = 1'b1;
        bus.alu_src_b_o   = 2'b00;
        bus.alu_op_o      = 3'b011;
        bus.pc_source_o   = 2'b01;
        bus.pc_write_eq_o = (r_op == 6'h04);
        bus.pc_write_ne_o = (r_op == 6'h05);
        bus.instr_done_o  = 1'b1;
        w_next            = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write_o   = 1'b1;
        bus.pc_source_o  = 2'b10;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      S_ILLEGAL: begin
        bus.illegal_op_o = 1'b1;
        bus.instr_done_o = 1'b1;
        w_next           = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.state_o = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into a per-cycle list of (inputs, expected outputs) derived from the
// instruction class and chosen wait counts, then played against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_eq;
    logic       pc_write_ne;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       done;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic       ready;
    logic [5:0] opc;
    exp_t       e;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;
  int   ill_cnt;
  logic [63:0] slog;
  cyc_t q[$];
  exp_t act;

  multicycle_control_if bus ();

  multicycle_control #(.USE_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.state_o, bus.pc_write_o, bus.pc_write_eq_o, bus.pc_write_ne_o,
                bus.pc_source_o, bus.ir_write_o, bus.i_or_d_o, bus.mem_read_o,
                bus.mem_write_o, bus.mem_to_reg_o, bus.reg_dst_o, bus.reg_write_o,
                bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.instr_done_o,
                bus.illegal_op_o};

  function automatic exp_t st(input logic [3:0] code);
    exp_t e;
    e = '0;
    e.state = code;
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic rdy);
    exp_t e;
    e = st(4'd0);
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    e.alu_op    = 3'b100;
    e.pc_write  = rdy;
    e.ir_write  = rdy;
    return e;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [5:0] opc, input exp_t e);
    cyc_t c;
    c.ready = rdy;
    c.opc   = opc;
    c.e     = e;
    q.push_back(c);
  endtask

  // Expected cycle list for one instruction, fw fetch waits, mw memory waits.
  task automatic plan_instr(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    for (int i = 0; i < fw; i++) push(1'b0, 6'($urandom), fetch_exp(1'b0));
    push(1'b1, 6'($urandom), fetch_exp(1'b1));
    e = st(4'd1); e.alu_src_b = 2'b11; e.alu_op = 3'b100;
    push(rnd_bit(), op, e);
    case (op)
      6'h00: begin
        e = st(4'd6); e.alu_src_a = 1'b1; e.alu_op = 3'b111;
        push(rnd_bit(), op, e);
        e = st(4'd7); e.reg_dst = 1'b1; e.reg_write = 1'b1; e.done = 1'b1;
        push(rnd_bit(), op, e);
      end
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin
        e = st(4'd8); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_op = (op == 6'h08) ? 3'b100 : (op == 6'h0c) ? 3'b010 :
                   (op == 6'h0d) ? 3'b001 : 3'b000;
        push(rnd_bit(), op, e);
        e = st(4'd9); e.reg_write = 1'b1; e.done = 1'b1;
        push(rnd_bit(), op, e);
      end
      6'h23, 6'h2b: begin
        e = st(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100;
        push(rnd_bit(), op, e);
        if (op == 6'h23) begin
          e = st(4'd3); e.i_or_d = 1'b1; e.mem_read = 1'b1;
          for (int i = 0; i < mw; i++) push(1'b0, op, e);
          push(1'b1, op, e);
          e = st(4'd4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.done = 1'b1;
          push(rnd_bit(), op, e);
        end else begin
          e = st(4'd5); e.i_or_d = 1'b1; e.mem_write = 1'b1;
          for (int i = 0; i < mw; i++) push(1'b0, op, e);
          e.done = 1'b1;
          push(1'b1, op, e);
        end
      end
      6'h04, 6'h05: begin
        e = st(4'd10); e.alu_src_a = 1'b1; e.alu_op = 3'b011; e.pc_source = 2'b01;
        e.pc_write_eq = (op == 6'h04); e.pc_write_ne = (op == 6'h05); e.done = 1'b1;
        push(rnd_bit(), op, e);
      end
      6'h02: begin
        e = st(4'd11); e.pc_write = 1'b1; e.pc_source = 2'b10; e.done = 1'b1;
        push(rnd_bit(), op, e);
      end
      default: begin
        e = st(4'd12); e.illegal = 1'b1; e.done = 1'b1;
        push(rnd_bit(), op, e);
      end
    endcase
  endtask

  task automatic check(input string name, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%h required=%h (state act=%0d req=%0d)",
               name, cyc_no, act, exp, act.state, exp.state);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] a, input logic [63:0] r);
    tests++;
    if (a !== r) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, a, r);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.mem_ready_i = c.ready;
      bus.opcode_i    = c.opc;
      @(negedge clk);
      check("cycle", c.e);
      slog = {slog[59:0], bus.state_o};
      if (bus.illegal_op_o) ill_cnt++;
      cyc_no++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] legal[10];
    logic [5:0] op;
    exp_t rst_exp;
    legal = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    bus.mem_ready_i = 1'b1;
    bus.opcode_i    = '0;

    // Reset held for 3 cycles: FETCH values with write strobes masked.
    rst_exp = fetch_exp(1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset", rst_exp);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    // R-type, zero wait.
    slog = '0;
    plan_instr(6'h00, 0, 0);
    play();
    check_val("r_type_states", slog[15:0], 64'h0167);

    // lw with 2 wait cycles in MEM_READ.
    slog = '0;
    plan_instr(6'h23, 0, 2);
    play();
    check_val("lw_states", slog[27:0], 64'h0123334);

    plan_instr(6'h04, 0, 0);
    plan_instr(6'h05, 1, 0);
    play();

    // Illegal opcode, then a normal instruction.
    slog = '0;
    ill_cnt = 0;
    plan_instr(6'h3f, 0, 0);
    play();
    check_val("illegal_states", slog[11:0], 64'h01C);
    check_val("illegal_pulse", 64'(ill_cnt), 64'd1);
    plan_instr(6'h08, 0, 0);
    play();

    // Randomized instruction mix with random wait states.
    for (int n = 0; n < 150; n++) begin
      int k;
      k = int'($urandom_range(0, 11));
      op = (k >= 10) ? 6'($urandom) : legal[k];
      plan_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    play();

    // Async reset while stalled in MEM_WRITE.
    plan_instr(6'h2b, 0, 3);
    void'(q.pop_back());
    play();
    bus.mem_ready_i = 1'b0;
    check_val("sw_stalled_state", 64'(bus.state_o), 64'd5);
    check_val("sw_stalled_memwrite", 64'(bus.mem_write_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_val("async_reset_state", 64'(bus.state_o), 64'd0);
    check_val("async_reset_memwrite", 64'(bus.mem_write_o), 64'd0);
    check_val("async_reset_pcwrite", 64'(bus.pc_write_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    plan_instr(6'h00, 1, 0);
    plan_instr(6'h2b, 0, 1);
    play();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
